sha256_msg_schedule: RTL
========================

// Module: sha256_msg_schedule
// PURPOSE
// - Message-schedule expander for the SHA-256 engine. Consumes the 16 words of one
//   512-bit block and produces the 64 schedule words W[0..63] for the round core.
// - W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] for t>=16, using a 16-entry ring.
// - Sits between the block loader (upstream) and the compression rounds (downstream).
// - Both sides use valid/ready handshakes. Throughput: 1 word/cycle.
// PARAMETERS
// - WORDS_IN   16  words per block; fixed by SHA-256; other values unsupported
// - WORDS_OUT  64  schedule length; fixed by SHA-256
// PORTS
// - clk        in   1   single clock, rising edge
// - rst        in   1   asynchronous, active-high reset
// - in_valid   in   1   in_data holds a valid message word
// - in_ready   out  1   block accepts a word (high only in LOAD)
// - in_data    in   32  message word, big-endian word order, M[0] first
// - out_valid  out  1   out_data/out_idx hold W[out_idx]
// - out_ready  in   1   round core accepts the word
// - out_data   out  32  schedule word W[t]
// - out_idx    out  6   t, 0..63
// - busy       out  1   high in LOAD-after-first-word and EXPAND
// - done       out  1   one-cycle pulse when W[63] handshake completes
// BEHAVIOUR
// - Reset values (async, immediate): state=LOAD, in_ready=0 until first clk after
//   deassert, out_valid=0, out_data=0, out_idx=0, busy=0, done=0.
// - Ring contents are not reset. Reset mid-block discards the block with no output.
// - FSM states: LOAD -> EXPAND -> LOAD.
// - LOAD:
//   - in_ready=1.
//   - Each in_valid&in_ready writes ring[load_cnt], load_cnt++.
//   - On the 16th accept: go to EXPAND, t=0.
// - EXPAND:
//   - in_ready=0.
//   - Output register loads when (!out_valid || out_ready).
//   - On load: out_data=W[t], out_idx=t, out_valid=1, t++.
//   - For t<16: W[t]=ring[t].
//   - For t>=16: W[t] is computed from ring[(t-2)&15], ring[(t-7)&15],
//     ring[(t-15)&15], ring[t&15]. The result is written to ring[t&15] in the
//     same cycle the output register loads.
// - Latency:
//   - First out_valid is 1 cycle after the 16th input accept.
//   - Continuous out_ready gives 64 consecutive valid cycles.
// - Backpressure:
//   - out_ready=0 holds out_data/out_idx/out_valid stable.
//   - While held, t does not advance and the ring is not written.
// - Arithmetic:
//   - s0(x) = ror7 ^ ror18 ^ shr3.
//   - s1(x) = ror17 ^ ror19 ^ shr10.
//   - Sums are modulo 2^32; carries are discarded.
// - End of block:
//   - When t=64 and the W[63] handshake occurs: out_valid=0 next cycle, done=1 for
//     one cycle, return to LOAD.
//   - Upstream may present the next block's words in the cycle after done.
// - Simultaneous events:
//   - in_valid during EXPAND is ignored (in_ready=0); the word is not consumed.
//   - out_ready with out_valid=0 has no effect.
// PIPELINE & STRUCTURE
// - Shared package sha256_pkg:
//   - WORD_W=32, BLOCK_WORDS=16, SCHED_WORDS=64.
//   - Functions sigma0/sigma1.
//   - State enum {LOAD, EXPAND}.
// - One sub-module, sha256_w_ring: 16x32 register file with one write port and four
//   combinational read ports, addressed by 4-bit indices.
// TESTING
// - Standard "abc" padded block:
//   - Input: M0=0x61626380, M1..M14=0, M15=0x00000018, out_ready=1.
//   - Required: W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6,
//     W63=0x12B1EDEB; done after W63.
// - Same block with out_ready toggled 1/0 every cycle:
//   - Identical W sequence.
//   - out_data/out_idx stable while out_ready=0.
//   - 64 handshakes total.
// - Two back-to-back blocks (abc, then all-0xFFFFFFFF):
//   - Second block is accepted from the cycle after done.
//   - Output matches the reference model; no leakage of ring state between blocks.
// - in_valid held high throughout EXPAND:
//   - in_ready=0.
//   - No word is consumed until the state returns to LOAD.
// - Async rst asserted mid-LOAD (after 7 words) and mid-EXPAND (out_idx=30):
//   - All outputs go to 0 immediately.
//   - A subsequent full block expands correctly from t=0.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants, schedule sigma functions and FSM state type for the
// SHA-256 message-schedule expander.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int SCHED_WORDS = 64;

  typedef enum logic [0:0] {
    LOAD   = 1'b0,
    EXPAND = 1'b1
  } state_e;

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_w_ring.sv
// 16x32 schedule ring: one synchronous write port, four combinational reads.
// Contents are deliberately not reset; every entry is written before use.
module sha256_w_ring
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [3:0]        raddr0,
  input  logic [3:0]        raddr1,
  input  logic [3:0]        raddr2,
  input  logic [3:0]        raddr3,
  output logic [WORD_W-1:0] rdata0,
  output logic [WORD_W-1:0] rdata1,
  output logic [WORD_W-1:0] rdata2,
  output logic [WORD_W-1:0] rdata3
);

  logic [WORD_W-1:0] mem_r [16];

  // ring write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata0 = mem_r[raddr0];
  assign rdata1 = mem_r[raddr1];
  assign rdata2 = mem_r[raddr2];
  assign rdata3 = mem_r[raddr3];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, streams W[0..63] at one word/cycle
// with valid/ready on both sides, recomputing W[t] in place in a 16-entry ring.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int WORDS_IN  = BLOCK_WORDS,
  parameter int WORDS_OUT = SCHED_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [5:0]        out_idx,
  output logic              busy,
  output logic              done
);

  state_e            state_r, state_s;
  logic [3:0]        load_cnt_r, load_cnt_s;
  logic [6:0]        t_r, t_s;
  logic              accept_s, first_s, adv_s, fin_s, load_out_s;
  logic              we_s;
  logic [3:0]        waddr_s;
  logic [WORD_W-1:0] wdata_s;
  logic [WORD_W-1:0] rd0_s, rd1_s, rd2_s, rd3_s;
  logic [WORD_W-1:0] w_calc_s, w_t_s;

  sha256_w_ring u_ring (
    .clk    (clk),
    .we     (we_s),
    .waddr  (waddr_s),
    .wdata  (wdata_s),
    .raddr0 (t_r[3:0] - 4'd2),
    .raddr1 (t_r[3:0] - 4'd7),
    .raddr2 (t_r[3:0] - 4'd15),
    .raddr3 (t_r[3:0]),
    .rdata0 (rd0_s),
    .rdata1 (rd1_s),
    .rdata2 (rd2_s),
    .rdata3 (rd3_s)
  );

  assign w_calc_s = sigma1(rd0_s) + rd1_s + sigma0(rd2_s) + rd3_s;
  assign w_t_s    = (t_r < 7'(BLOCK_WORDS)) ? rd3_s : w_calc_s;

  // W[0] is launched on the last accept (t_r is 0 in LOAD) for one-cycle latency
  always_comb begin
    accept_s   = (state_r == LOAD) && in_valid && in_ready;
    first_s    = accept_s && (load_cnt_r == 4'(WORDS_IN - 1));
    adv_s      = (state_r == EXPAND) && (!out_valid || out_ready) && (t_r < 7'(WORDS_OUT));
    fin_s      = (state_r == EXPAND) && out_valid && out_ready && (t_r == 7'(WORDS_OUT));
    load_out_s = first_s || adv_s;
    load_cnt_s = accept_s ? (load_cnt_r + 4'd1) : load_cnt_r;
    if (load_out_s) begin
      t_s = t_r + 7'd1;
    end else if (fin_s) begin
      t_s = 7'd0;
    end else begin
      t_s = t_r;
    end
  end

  // next state and ring write-port steering
  always_comb begin
    state_s = state_r;
    we_s    = 1'b0;
    waddr_s = 4'd0;
    wdata_s = '0;
    case (state_r)
      LOAD: begin
        we_s    = accept_s;
        waddr_s = load_cnt_r;
        wdata_s = in_data;
        if (first_s) begin
          state_s = EXPAND;
        end else begin
          state_s = LOAD;
        end
      end
      EXPAND: begin
        we_s    = adv_s && (t_r >= 7'(BLOCK_WORDS));
        waddr_s = t_r[3:0];
        wdata_s = w_calc_s;
        if (fin_s) begin
          state_s = LOAD;
        end else begin
          state_s = EXPAND;
        end
      end
      default: begin
        state_s = LOAD;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= LOAD;
      load_cnt_r <= 4'd0;
      t_r        <= 7'd0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= 6'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      load_cnt_r <= load_cnt_s;
      t_r        <= t_s;
      in_ready   <= (state_s == LOAD);
      busy       <= (state_s == EXPAND) || (load_cnt_s != 4'd0);
      done       <= fin_s;
      if (load_out_s) begin
        out_data  <= w_t_s;
        out_idx   <= t_r[5:0];
        out_valid <= 1'b1;
      end else if (fin_s) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
